ram_top: RTL and testbench

//  Demo top: 256x8 single-port RAM, a fill sequencer and a UART transmitter.
//  key1 press fills RAM[a] = a for a = 0..255. key2 press reads RAM[0..255] in order
//  and sends each byte on rs232_tx as 8N1.

---
 rtl/ram_pkg.sv | 13 +
 rtl/ram_top_uart_byte_tx.sv | 58 +++++
 rtl/ram_top.sv | 125 ++++++++++++
 tb/tb_ram_top.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared constants, FSM state type and baud divisor helper for ram_top
package ram_pkg;
  localparam int RAM_DEPTH = 256;
  localparam int RAM_WIDTH = 8;
  localparam int ADDR_W = $clog2(RAM_DEPTH);
  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int BAUD_DEF = 115_200;
  typedef enum logic [1:0] {IDLE, FILL, DUMP} state_t;
  function automatic int calc_baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
  localparam int BAUD_DIV_DEF = calc_baud_div(CLK_FREQ_DEF, BAUD_DEF);
endpackage

// File: rtl/ram_top_uart_byte_tx.sv
// uart_byte_tx: 8N1 serializer, one byte per send_en, tx_done pulse at end of stop bit
module uart_byte_tx
  import ram_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 send_en,
  input  logic [RAM_WIDTH-1:0] data,
  output logic                 tx,
  output logic                 tx_done,
  output logic                 busy
);
  localparam int CNT_W = $clog2(BAUD_DIV + 1);
  logic [CNT_W-1:0] r_cnt;
  logic [3:0] r_bit;
  logic [8:0] r_shift;
  logic r_tx, r_done, r_busy;
  // start bit goes out on load; every BAUD_DIV clocks the next data/stop bit is shifted onto the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_bit <= '0;
      r_shift <= '1;
      r_tx <= 1'b1;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (send_en) begin
          r_shift <= {1'b1, data};
          r_tx <= 1'b0;
          r_busy <= 1'b1;
          r_cnt <= '0;
          r_bit <= '0;
        end
      end else if (r_cnt == CNT_W'(BAUD_DIV - 1)) begin
        r_cnt <= '0;
        if (r_bit == 4'd9) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_tx <= 1'b1;
        end else begin
          r_bit <= r_bit + 1'b1;
          r_tx <= r_shift[0];
          r_shift <= {1'b1, r_shift[8:1]};
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  assign tx = r_tx;
  assign tx_done = r_done;
  assign busy = r_busy;
endmodule

// File: rtl/ram_top.sv
// ram_top: key1 fills a 256x8 RAM with its own addresses, key2 dumps it over an 8N1 UART
module ram_top
  import ram_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_DEF,
  parameter int BAUD       = BAUD_DEF,
  parameter int KEY_STABLE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key1,
  input  logic key2,
  output logic rs232_tx,
  output logic state_led,
  output logic tx_done
);
  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam int KC_W = $clog2(KEY_STABLE + 1);
  logic [1:0] r_rst_sync;
  logic w_rst_n;
  logic [1:0] r_key_s1, r_key_s2, r_key_lvl, r_key_ev;
  logic [KC_W-1:0] r_key_cnt [2];
  state_t r_state;
  logic [ADDR_W-1:0] r_addr;
  logic r_led, r_send, r_wait;
  logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] r_rdata;
  logic w_tx, w_tx_done, w_busy;
  // reset asserts immediately but releases on a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= '0;
    else r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];
  // synchronize keys, accept a level after KEY_STABLE equal samples, pulse on each accepted press
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_key_s1 <= '1;
      r_key_s2 <= '1;
      r_key_lvl <= '1;
      r_key_ev <= '0;
      r_key_cnt <= '{default: '0};
    end else begin
      r_key_s1 <= {key2, key1};
      r_key_s2 <= r_key_s1;
      for (int k = 0; k < 2; k++) begin
        r_key_ev[k] <= 1'b0;
        if (r_key_s2[k] == r_key_lvl[k]) r_key_cnt[k] <= '0;
        else if (r_key_cnt[k] == KC_W'(KEY_STABLE - 1)) begin
          r_key_cnt[k] <= '0;
          r_key_lvl[k] <= r_key_s2[k];
          r_key_ev[k] <= r_key_lvl[k];
        end else r_key_cnt[k] <= r_key_cnt[k] + 1'b1;
      end
    end
  end
  // sequencer: fill writes one address per clock; dump hands one byte to the UART per frame
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_led <= 1'b0;
      r_send <= 1'b0;
      r_wait <= 1'b0;
    end else begin
      r_send <= 1'b0;
      case (r_state)
        IDLE: begin
          r_addr <= '0;
          r_wait <= 1'b0;
          if (r_key_ev[0]) begin
            r_state <= FILL;
            r_led <= 1'b1;
          end else if (r_key_ev[1]) begin
            r_state <= DUMP;
            r_led <= 1'b1;
          end
        end
        FILL: begin
          r_addr <= r_addr + 1'b1;
          if (&r_addr) begin
            r_state <= IDLE;
            r_led <= 1'b0;
          end
        end
        DUMP: begin
          if (!r_wait) begin
            if (!w_busy) begin
              r_send <= 1'b1;
              r_wait <= 1'b1;
            end
          end else if (w_tx_done) begin
            r_wait <= 1'b0;
            r_addr <= r_addr + 1'b1;
            if (&r_addr) begin
              r_state <= IDLE;
              r_led <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_led <= 1'b0;
        end
      endcase
    end
  end
  // single-port RAM: fill writes addr as data, read data appears one clock after the address
  always_ff @(posedge clk) begin
    if (r_state == FILL) r_mem[r_addr] <= r_addr;
    r_rdata <= r_mem[r_addr];
  end
  uart_byte_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk(clk),
    .rst_n(w_rst_n),
    .send_en(r_send),
    .data(r_rdata),
    .tx(w_tx),
    .tx_done(w_tx_done),
    .busy(w_busy)
  );
  assign rs232_tx = w_tx;
  assign tx_done = w_tx_done;
  assign state_led = r_led;
endmodule

// File: tb/tb_ram_top.sv
// tb_ram_top: self-checking bench for ram_top key filtering, fill, UART dump and reset abort
module tb_ram_top;
  localparam int CLK_FREQ = 40_000_000;
  localparam int BAUD = 5_000_000;
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int KS = 4;
  localparam int FRAME = 10 * DIV;

  logic clk = 0, rst_n = 1, key1 = 1, key2 = 1;
  logic rs232_tx, state_led, tx_done;
  int total = 0, bad = 0;
  int cyc = 0;
  int fr_err = 0;
  byte unsigned rx_q[$];
  int done_t[$];
  logic [7:0] model_mem [256];

  typedef struct { int which; int len; int exp_hi; } vec_t;
  typedef struct { int addr; int exp; } mem_t;

  ram_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .KEY_STABLE(KS)) dut (
    .clk(clk), .rst_n(rst_n), .key1(key1), .key2(key2),
    .rs232_tx(rs232_tx), .state_led(state_led), .tx_done(tx_done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tx_done) done_t.push_back(cyc);

  // UART receiver: mid-bit sampling, frames interrupted by reset are dropped
  initial begin : uart_mon
    logic [7:0] b;
    logic ok, stop_bit;
    int j;
    forever begin
      @(negedge clk);
      if (rst_n && !rs232_tx) begin
        ok = 1; b = '0; stop_bit = 0;
        for (int t = 1; t <= DIV / 2 + 9 * DIV; t++) begin
          @(negedge clk);
          ok &= rst_n;
          if (t >= DIV / 2 && (t - DIV / 2) % DIV == 0) begin
            j = (t - DIV / 2) / DIV;
            if (j == 0 && rs232_tx) ok = 0;
            else if (j >= 1 && j <= 8) b[j-1] = rs232_tx;
            else if (j == 9) stop_bit = rs232_tx;
          end
        end
        if (ok) begin
          rx_q.push_back(b);
          if (!stop_bit) fr_err++;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // spec rule: a press is accepted only when held for at least KEY_STABLE samples; a fill lights the LED 256 clocks
  function automatic int fill_cycles(input int len);
    return (len >= KS) ? 256 : 0;
  endfunction

  task automatic press(input int which, input int len, output int hi);
    hi = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      key1 = !((which & 1) != 0 && c < len);
      key2 = !((which & 2) != 0 && c < len);
      hi += state_led ? 1 : 0;
      if (c > len + KS + 12 && !state_led) break;
    end
    key1 = 1; key2 = 1;
  endtask

  initial begin
    vec_t vecs[$];
    mem_t mvecs[$];
    int hi, base, dbase, timeout, gap_bad, k1_at, k2_at, ok, dc, rc, lowcnt, l;
    vecs.push_back('{2, 3, 0});
    vecs.push_back('{1, 1, 0});
    vecs.push_back('{1, KS - 1, 0});
    vecs.push_back('{1, KS, 256});
    vecs.push_back('{1, 20, 256});
    vecs.push_back('{3, 6, 256});
    vecs.push_back('{2, KS - 1, 0});
    for (int i = 0; i < 6; i++) begin
      l = $urandom_range(1, 2 * KS);
      vecs.push_back('{1, l, fill_cycles(l)});
    end
    #2 rst_n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_outputs", {rs232_tx, state_led, tx_done}, 3'b100);
    end
    rst_n = 1;
    repeat (5) @(negedge clk);
    foreach (vecs[i]) begin
      press(vecs[i].which, vecs[i].len, hi);
      check($sformatf("press_led_cycles[%0d]", i), hi, vecs[i].exp_hi);
      if (vecs[i].exp_hi != 0) for (int a = 0; a < 256; a++) model_mem[a] = 8'(a);
      repeat (10) @(negedge clk);
    end
    check("no_uart_bytes_after_fill", rx_q.size(), 0);
    check("no_tx_done_after_fill", done_t.size(), 0);
    mvecs.push_back('{0, int'(model_mem[0])});
    mvecs.push_back('{8'h5A, int'(model_mem[8'h5A])});
    mvecs.push_back('{255, int'(model_mem[255])});
    for (int i = 0; i < 5; i++) begin
      l = $urandom_range(0, 255);
      mvecs.push_back('{l, int'(model_mem[l])});
    end
    foreach (mvecs[i]) check($sformatf("ram_backdoor[%0d]", mvecs[i].addr), int'(dut.r_mem[mvecs[i].addr]), mvecs[i].exp);
    // full dump with stray key1/key2 presses that must be ignored
    base = rx_q.size(); dbase = done_t.size();
    k1_at = $urandom_range(300, 8000); k2_at = $urandom_range(9000, 18000);
    timeout = 1;
    for (int c = 0; c < 256 * (FRAME + 3) + 600; c++) begin
      @(negedge clk);
      key2 = !(c < 6 || (c >= k2_at && c < k2_at + 8));
      key1 = !(c >= k1_at && c < k1_at + 8);
      if (c > 20 && !state_led) begin timeout = 0; break; end
    end
    key1 = 1; key2 = 1;
    check("dump_timeout", timeout, 0);
    repeat (20) @(negedge clk);
    check("dump_frames", rx_q.size() - base, 256);
    for (int i = 0; i < 256; i++)
      if (base + i < rx_q.size()) check($sformatf("dump_byte[%0d]", i), int'(rx_q[base+i]), int'(model_mem[i]));
    check("dump_tx_done_count", done_t.size() - dbase, 256);
    gap_bad = 0;
    for (int i = dbase + 1; i < done_t.size(); i++)
      if (done_t[i] - done_t[i-1] < FRAME || done_t[i] - done_t[i-1] > FRAME + 3) gap_bad++;
    check("tx_done_gap_bad", gap_bad, 0);
    check("frame_errors", fr_err, 0);
    check("idle_after_dump", {rs232_tx, state_led}, 2'b10);
    // reset in the middle of a start bit
    base = rx_q.size();
    @(negedge clk) key2 = 0;
    repeat (6) @(negedge clk);
    key2 = 1;
    ok = 0;
    for (int c = 0; c < 4 * FRAME; c++) begin
      @(negedge clk);
      if (rx_q.size() >= base + 2) begin ok = 1; break; end
    end
    check("wait_two_frames", ok, 1);
    ok = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      if (!rs232_tx) begin ok = 1; break; end
    end
    check("wait_start_bit", ok, 1);
    @(negedge clk);
    check("start_bit_low", rs232_tx, 0);
    check("led_during_dump", state_led, 1);
    dc = done_t.size(); rc = rx_q.size();
    #2 rst_n = 0;
    #1;
    check("reset_tx_high", rs232_tx, 1);
    check("reset_led_low", state_led, 0);
    repeat (3) @(negedge clk);
    check("reset_tx_done_low", tx_done, 0);
    rst_n = 1;
    lowcnt = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      lowcnt += rs232_tx ? 0 : 1;
    end
    check("line_idle_after_reset", lowcnt, 0);
    check("no_tx_done_after_reset", done_t.size() - dc, 0);
    check("no_frame_after_reset", rx_q.size() - rc, 0);
    check("led_low_after_reset", state_led, 0);
    press(1, 6, hi);
    check("fill_after_reset", hi, fill_cycles(6));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
